// File: rtl/exec_mem_unit.sv
// Execute/memory stage: PC incrementer, branch-target adder, 32-bit ALU and word-addressed data memory.
// Optional feature: define ALU_OVERFLOW_EN to drive signed overflow on ADD/SUB (otherwise overflow=0).
module exec_mem_unit #(
   parameter int unsigned DEPTH     = 1024,
   parameter int unsigned OUT1_ADDR = 2000,
   parameter int unsigned OUT2_ADDR = 2004
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc,
   input  logic [31:0] imm_ext,
   output logic [31:0] pc_plus4,
   output logic [31:0] branch_target,
   input  logic [31:0] alu_a,
   input  logic [31:0] alu_b,
   input  logic [3:0]  alu_op,
   output logic [31:0] alu_result,
   output logic        zero,
   output logic        overflow,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic [31:0] out1,
   output logic [31:0] out2
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0] OUT1_IDX = AW'(OUT1_ADDR / 4);
   localparam logic [AW-1:0] OUT2_IDX = AW'(OUT2_ADDR / 4);

   typedef enum logic [3:0] {
      OP_AND  = 4'b0000,
      OP_OR   = 4'b0001,
      OP_ADD  = 4'b0010,
      OP_SLTU = 4'b0011,
      OP_SUB  = 4'b0110,
      OP_SLT  = 4'b0111,
      OP_SLL  = 4'b1000,
      OP_SRL  = 4'b1001,
      OP_XOR  = 4'b1010,
      OP_SRA  = 4'b1011,
      OP_NOR  = 4'b1100,
      OP_LUI  = 4'b1101
   } alu_op_e;

   logic [31:0] mem_q [DEPTH];
   alu_op_e     op;
   logic [4:0]  shamt;
   logic [31:0] idx_ext;
   logic        in_range;
   logic [AW-1:0] widx;

   assign pc_plus4      = pc + 32'd4;
   assign branch_target = pc_plus4 + (imm_ext << 2);

   assign op    = alu_op_e'(alu_op);
   assign shamt = alu_a[4:0];

   always_comb begin
      alu_result = '0;
      case (op)
         OP_AND:  alu_result = alu_a & alu_b;
         OP_OR:   alu_result = alu_a | alu_b;
         OP_ADD:  alu_result = alu_a + alu_b;
         OP_SUB:  alu_result = alu_a - alu_b;
         OP_SLT:  alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
         OP_SLTU: alu_result = {31'b0, alu_a < alu_b};
         OP_NOR:  alu_result = ~(alu_a | alu_b);
         OP_XOR:  alu_result = alu_a ^ alu_b;
         OP_SLL:  alu_result = alu_b << shamt;
         OP_SRL:  alu_result = alu_b >> shamt;
         OP_SRA:  alu_result = $signed(alu_b) >>> shamt;
         OP_LUI:  alu_result = {alu_b[15:0], 16'h0000};
         default: alu_result = '0;
      endcase
   end

   assign zero = (alu_result == '0);

`ifdef ALU_OVERFLOW_EN
   always_comb begin
      overflow = 1'b0;
      if (op == OP_ADD)
         overflow = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
      else if (op == OP_SUB)
         overflow = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
   end
`else
   assign overflow = 1'b0;
`endif

   // Word index drops the byte offset; the range check guards both read and write.
   assign idx_ext  = {2'b00, alu_result[31:2]};
   assign in_range = (idx_ext < DEPTH);
   assign widx     = idx_ext[AW-1:0];

   assign mem_rdata = (mem_read && in_range) ? mem_q[widx] : '0;
   assign out1      = mem_q[OUT1_IDX];
   assign out2      = mem_q[OUT2_IDX];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (mem_write && in_range) begin
         mem_q[widx] <= mem_wdata;
      end
   end

endmodule

// File: tb/tb_exec_mem_unit.sv
// Scoreboard bench for exec_mem_unit: stimulus pushes expected responses, a negedge monitor pops and compares.
module tb_exec_mem_unit;

   localparam int unsigned DEPTH = 1024;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc, imm_ext, pc_plus4, branch_target;
   logic [31:0] alu_a, alu_b, alu_result;
   logic [3:0]  alu_op;
   logic        zero, overflow, mem_read, mem_write;
   logic [31:0] mem_wdata, mem_rdata, out1, out2;

   exec_mem_unit #(.DEPTH(DEPTH), .OUT1_ADDR(2000), .OUT2_ADDR(2004)) dut (
      .clk(clk), .rst(rst), .pc(pc), .imm_ext(imm_ext), .pc_plus4(pc_plus4),
      .branch_target(branch_target), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_result(alu_result), .zero(zero), .overflow(overflow), .mem_read(mem_read),
      .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .out1(out1), .out2(out2)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc4, bt, res;
      logic        z, ov;
      logic [31:0] rd, o1, o2;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] ref_mem [int];
   int          errors = 0;
   int          checks = 0;

   function automatic logic [31:0] mem_get(int idx);
      return ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
   endfunction

   function automatic logic [31:0] ref_alu(logic [3:0] op, logic [31:0] a, logic [31:0] b);
      int s;
      s = int'(a[4:0]);
      case (op)
         4'd0:  return a & b;
         4'd1:  return a | b;
         4'd2:  return a + b;
         4'd6:  return a - b;
         4'd7:  return (longint'($signed(a)) < longint'($signed(b))) ? 32'd1 : 32'd0;
         4'd3:  return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
         4'd12: return ~(a | b);
         4'd10: return a ^ b;
         4'd8:  return b << s;
         4'd9:  return b >> s;
         4'd11: return (b >> s) | (b[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
         4'd13: return b * 32'd65536;
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic ref_ovf(logic [3:0] op, logic [31:0] a, logic [31:0] b);
`ifdef ALU_OVERFLOW_EN
      longint r;
      if (op == 4'd2) r = longint'($signed(a)) + longint'($signed(b));
      else if (op == 4'd6) r = longint'($signed(a)) - longint'($signed(b));
      else return 1'b0;
      return (r > 64'sd2147483647) || (r < -64'sd2147483648);
`else
      return 1'b0;
`endif
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic apply(input logic r, input logic [31:0] p, im, a, b, input logic [3:0] op,
                        input logic rd, wr, input logic [31:0] wd);
      exp_t        e;
      logic [31:0] idx;
      rst = r; pc = p; imm_ext = im; alu_a = a; alu_b = b; alu_op = op;
      mem_read = rd; mem_write = wr; mem_wdata = wd;
      e.pc4 = p + 32'd4;
      e.bt  = p + 32'd4 + im * 32'd4;
      e.res = ref_alu(op, a, b);
      e.z   = (e.res == 32'h0);
      e.ov  = ref_ovf(op, a, b);
      idx   = e.res / 32'd4;
      e.rd  = (rd && idx < DEPTH) ? mem_get(int'(idx)) : 32'h0;
      e.o1  = mem_get(2000 / 4);
      e.o2  = mem_get(2004 / 4);
      sb.push_back(e);
      @(posedge clk);
      if (r) ref_mem.delete();
      else if (wr && idx < DEPTH) ref_mem[int'(idx)] = wd;
      #1;
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         chk("pc_plus4", pc_plus4, e.pc4);
         chk("branch_target", branch_target, e.bt);
         chk("alu_result", alu_result, e.res);
         chk("zero", {31'b0, zero}, {31'b0, e.z});
         chk("overflow", {31'b0, overflow}, {31'b0, e.ov});
         chk("mem_rdata", mem_rdata, e.rd);
         chk("out1", out1, e.o1);
         chk("out2", out2, e.o2);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] a, b;
      rst = 1'b1; pc = '0; imm_ext = '0; alu_a = '0; alu_b = '0; alu_op = '0;
      mem_read = 1'b0; mem_write = 1'b0; mem_wdata = '0;
      @(posedge clk); #1;
      ref_mem.delete();

      apply(0, 32'h40, 32'hFFFF_FFFF, 32'd5, 32'd5, 4'b0110, 1, 0, 0);   // SUB -> zero
      apply(0, 32'h40, 32'h0000_0010, 32'hFFFF_FFFF, 32'd1, 4'b0111, 0, 0, 0); // SLT
      apply(0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'd1, 4'b0011, 0, 0, 0);  // SLTU
      apply(0, 32'h0, 32'h0, 32'd4, 32'h1, 4'b1000, 0, 0, 0);          // SLL
      apply(0, 32'h0, 32'h0, 32'd4, 32'h8000_0000, 4'b1011, 0, 0, 0);  // SRA
      apply(0, 32'h0, 32'h0, 32'h7FFF_FFFF, 32'd1, 4'b0010, 0, 0, 0);  // ADD overflow
      apply(0, 32'h0, 32'h0, 32'h8000_0000, 32'd1, 4'b0110, 0, 0, 0);  // SUB overflow
      apply(0, 32'h0, 32'h0, 32'd3, 32'hFFFF_1234, 4'b1101, 0, 0, 0);  // LUI
      apply(0, 32'h0, 32'h0, 32'd7, 32'd7, 4'b1111, 0, 0, 0);          // undefined op
      apply(0, 32'h0, 32'h0, 32'd2000, 32'd0, 4'b0010, 0, 1, 32'hDEAD_BEEF);
      apply(0, 32'h0, 32'h0, 32'd2000, 32'd2, 4'b0010, 1, 0, 0);
      apply(0, 32'h0, 32'h0, 32'd2000, 32'd0, 4'b0010, 0, 0, 0);
      apply(0, 32'h0, 32'h0, 32'd4096, 32'd0, 4'b0010, 0, 1, 32'h1234_5678);
      apply(0, 32'h0, 32'h0, 32'd4096, 32'd0, 4'b0010, 1, 0, 0);
      apply(0, 32'h0, 32'h0, 32'd4092, 32'd0, 4'b0010, 0, 1, 32'hA5A5_0001); // last word
      apply(0, 32'h0, 32'h0, 32'd4092, 32'd0, 4'b0010, 1, 0, 0);
      apply(0, 32'h0, 32'h0, 32'd2004, 32'd0, 4'b0010, 1, 1, 32'hCAFE_F00D); // old value first
      apply(0, 32'h0, 32'h0, 32'd2004, 32'd0, 4'b0010, 1, 0, 0);
      apply(1, 32'h0, 32'h0, 32'd2004, 32'd0, 4'b0010, 1, 1, 32'h5555_AAAA); // reset beats write
      apply(0, 32'h0, 32'h0, 32'd2004, 32'd0, 4'b0010, 1, 0, 0);
      apply(0, 32'h0, 32'h0, 32'd2000, 32'd0, 4'b0010, 1, 0, 0);

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 1) == 0) begin
            a = $urandom();
            if ($urandom_range(0, 2) == 0) a = {27'b0, a[4:0]};
            b = $urandom();
            apply($urandom_range(0, 99) == 0, $urandom(), $urandom(), a, b,
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom());
         end else begin
            case ($urandom_range(0, 3))
               0: a = 32'd2000;
               1: a = 32'd2004;
               default: a = 32'($urandom_range(0, 1100)) * 32'd4;
            endcase
            apply($urandom_range(0, 99) == 0, $urandom(), $urandom(), a,
                  32'($urandom_range(0, 3)), 4'b0010, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom());
         end
      end

      repeat (2) @(negedge clk);
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
